// File: rtl/rv32v_types_pkg.sv
// Shared vector-unit types plus the reduction sequencer state, op record and operand helpers.
package rv32v_types_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        VALU_ADD = 4'd0,
        VALU_SUB = 4'd1,
        VALU_AND = 4'd2,
        VALU_OR  = 4'd3,
        VALU_XOR = 4'd4,
        VALU_MIN = 4'd5,
        VALU_MAX = 4'd6,
        VALU_SLL = 4'd7,
        VALU_SRL = 4'd8,
        VALU_SRA = 4'd9
    } valuop_t;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } vsew_t;

    typedef enum logic [1:0] {
        RED_IDLE,
        RED_FETCH,
        RED_DRAIN,
        RED_DONE
    } red_state_t;

    // Op fields latched at start and held for the whole reduction.
    typedef struct packed {
        valuop_t op;
        logic    uns;
        vsew_t   sew;
    } red_op_t;

    // Operations the reduction unit can fold.
    function automatic logic red_legal_op(input valuop_t op);
        case (op)
            VALU_ADD, VALU_AND, VALU_OR, VALU_XOR, VALU_MIN, VALU_MAX: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Low-SEW-bit mask for the final result.
    function automatic logic [XLEN-1:0] sew_mask(input vsew_t sew);
        case (sew)
            SEW8:    return 32'h0000_00ff;
            SEW16:   return 32'h0000_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    // Truncate to SEW, then sign- or zero-extend back to XLEN.
    function automatic logic [XLEN-1:0] sew_extend(input logic [XLEN-1:0] x, input vsew_t sew,
                                                   input logic uns);
        case (sew)
            SEW8:    return uns ? {24'h0, x[7:0]}  : {{24{x[7]}}, x[7:0]};
            SEW16:   return uns ? {16'h0, x[15:0]} : {{16{x[15]}}, x[15:0]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/rv32v_red_alu.sv
// Combinational fold of one element into the extended accumulator.
module rv32v_red_alu
    import rv32v_types_pkg::*;
(
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] elem,
    input  valuop_t         op,
    input  vsew_t           sew,
    input  logic            uns,
    output logic [XLEN-1:0] acc_next_c
);

    logic [XLEN-1:0] elem_x;
    logic [XLEN-1:0] raw;
    logic            acc_lt;

    // Extend the element, compare, and re-extend so ADD wraps at SEW.
    always_comb begin
        elem_x = sew_extend(elem, sew, uns);
        acc_lt = uns ? (acc < elem_x) : ($signed(acc) < $signed(elem_x));
        case (op)
            VALU_ADD: raw = acc + elem_x;
            VALU_AND: raw = acc & elem_x;
            VALU_OR:  raw = acc | elem_x;
            VALU_XOR: raw = acc ^ elem_x;
            VALU_MIN: raw = acc_lt ? acc : elem_x;
            VALU_MAX: raw = acc_lt ? elem_x : acc;
            default:  raw = acc;
        endcase
        acc_next_c = sew_extend(raw, sew, uns);
    end

endmodule

// File: rtl/rv32v_red_sequencer.sv
// VFU_RED controller: fetches vs2[0..vl-1] over a pipelined read port and folds active
// elements into an accumulator seeded from vs1[0].
module rv32v_red_sequencer
    import rv32v_types_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned VLMAX           = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       start,
    input  valuop_t                    valuop,
    input  logic                       vopunsigned,
    input  vsew_t                      vsew,
    input  logic [$clog2(VLMAX):0]     vl,
    input  logic                       vm,
    input  logic [31:0]                scalar_init,
    input  logic                       flush,
    output logic                       busy,
    output logic                       illegal,
    output logic                       elem_req_valid,
    input  logic                       elem_req_ready,
    output logic [$clog2(VLMAX)-1:0]   elem_idx,
    input  logic                       elem_rsp_valid,
    input  logic [31:0]                elem_rsp_data,
    input  logic                       elem_rsp_mask,
    output logic                       done,
    output logic                       result_we,
    output logic [31:0]                result
);

    localparam int unsigned VL_W  = $clog2(VLMAX) + 1;
    localparam int unsigned IDX_W = $clog2(VLMAX);

    red_state_t      state_q, state_d;
    red_op_t         op_q, op_d;
    logic [VL_W-1:0] vl_q, vl_d;
    logic            vm_q, vm_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [VL_W-1:0] req_cnt_q, req_cnt_d;
    logic [VL_W-1:0] rsp_cnt_q, rsp_cnt_d;

    logic              busy_q, busy_d;
    logic              illegal_q, illegal_d;
    logic              req_valid_q, req_valid_d;
    logic [IDX_W-1:0]  elem_idx_q, elem_idx_d;
    logic              done_q, done_d;
    logic              result_we_q, result_we_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [VL_W-1:0] outstanding;
    logic [VL_W-1:0] outstanding_d;
    logic            req_fire;
    logic            rsp_fire;
    logic [XLEN-1:0] alu_acc_c;

    rv32v_red_alu u_alu (
        .acc        (acc_q),
        .elem       (elem_rsp_data),
        .op         (op_q.op),
        .sew        (op_q.sew),
        .uns        (op_q.uns),
        .acc_next_c (alu_acc_c)
    );

    // Next-state, counter, accumulator and registered-output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        vl_d        = vl_q;
        vm_d        = vm_q;
        acc_d       = acc_q;
        req_cnt_d   = req_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        illegal_d   = 1'b0;

        outstanding = req_cnt_q - rsp_cnt_q;
        req_fire    = req_valid_q && elem_req_ready;
        rsp_fire    = elem_rsp_valid && (outstanding != '0) &&
                      ((state_q == RED_FETCH) || (state_q == RED_DRAIN));

        // Responses come back in request order; rsp_fire is already state-gated.
        if (rsp_fire) begin
            rsp_cnt_d = rsp_cnt_q + VL_W'(1);
            if (vm_q || elem_rsp_mask) begin
                acc_d = alu_acc_c;
            end
        end

        case (state_q)
            RED_IDLE: begin
                if (start && !flush) begin
                    if (red_legal_op(valuop)) begin
                        op_d.op   = valuop;
                        op_d.uns  = vopunsigned;
                        op_d.sew  = vsew;
                        vl_d      = vl;
                        vm_d      = vm;
                        acc_d     = sew_extend(scalar_init, vsew, vopunsigned);
                        req_cnt_d = '0;
                        rsp_cnt_d = '0;
                        state_d   = (vl == '0) ? RED_DONE : RED_FETCH;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            RED_FETCH: begin
                if (req_fire) begin
                    req_cnt_d = req_cnt_q + VL_W'(1);
                end
                if (req_cnt_d == vl_q) begin
                    state_d = RED_DRAIN;
                end
            end
            RED_DRAIN: begin
                if (rsp_cnt_q == vl_q) begin
                    state_d = RED_DONE;
                end
            end
            RED_DONE: begin
                state_d = RED_IDLE;
            end
            default: begin
                state_d = RED_IDLE;
            end
        endcase

        // Abort drops everything; in-flight responses are ignored once back in IDLE.
        if (flush && (state_q != RED_IDLE)) begin
            state_d   = RED_IDLE;
            op_d      = '0;
            vl_d      = '0;
            vm_d      = 1'b0;
            acc_d     = '0;
            req_cnt_d = '0;
            rsp_cnt_d = '0;
        end

        outstanding_d = req_cnt_d - rsp_cnt_d;
        busy_d        = (state_d != RED_IDLE);
        req_valid_d   = (state_d == RED_FETCH) && (req_cnt_d < vl_d) &&
                        (outstanding_d < VL_W'(MAX_OUTSTANDING));
        elem_idx_d    = req_valid_d ? req_cnt_d[IDX_W-1:0] : '0;
        done_d        = (state_d == RED_DONE);
        result_we_d   = done_d && (vl_d != '0);
        result_d      = done_d ? (acc_d & sew_mask(op_d.sew)) : '0;
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RED_IDLE;
            op_q        <= '0;
            vl_q        <= '0;
            vm_q        <= 1'b0;
            acc_q       <= '0;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            req_valid_q <= 1'b0;
            elem_idx_q  <= '0;
            done_q      <= 1'b0;
            result_we_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            vl_q        <= vl_d;
            vm_q        <= vm_d;
            acc_q       <= acc_d;
            req_cnt_q   <= req_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
            req_valid_q <= req_valid_d;
            elem_idx_q  <= elem_idx_d;
            done_q      <= done_d;
            result_we_q <= result_we_d;
            result_q    <= result_d;
        end
    end

    assign busy           = busy_q;
    assign illegal        = illegal_q;
    assign elem_req_valid = req_valid_q;
    assign elem_idx       = elem_idx_q;
    assign done           = done_q;
    assign result_we      = result_we_q;
    assign result         = result_q;

    // A response with nothing in flight means the read port broke protocol.
    a_no_orphan_rsp: assert property (@(posedge CLK) disable iff (!nRST)
        (elem_rsp_valid && !flush && ((state_q == RED_FETCH) || (state_q == RED_DRAIN)))
        |-> (outstanding != '0));

    // Request throttling must keep in-flight elements within the window.
    a_window: assert property (@(posedge CLK) disable iff (!nRST)
        outstanding <= VL_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_rv32v_red_sequencer.sv
// Directed bench for rv32v_red_sequencer with a latency/backpressure read-port model.
module tb_rv32v_red_sequencer;
    import rv32v_types_pkg::*;

    logic        CLK, nRST, start, vopunsigned, vm, flush;
    valuop_t     valuop;
    vsew_t       vsew;
    logic [5:0]  vl;
    logic [31:0] scalar_init;
    logic        busy, illegal, elem_req_valid, elem_req_ready;
    logic [4:0]  elem_idx;
    logic        elem_rsp_valid, elem_rsp_mask;
    logic [31:0] elem_rsp_data;
    logic        done, result_we;
    logic [31:0] result;

    rv32v_red_sequencer #(.MAX_OUTSTANDING(4), .VLMAX(32)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .valuop(valuop), .vopunsigned(vopunsigned),
        .vsew(vsew), .vl(vl), .vm(vm), .scalar_init(scalar_init), .flush(flush),
        .busy(busy), .illegal(illegal), .elem_req_valid(elem_req_valid),
        .elem_req_ready(elem_req_ready), .elem_idx(elem_idx), .elem_rsp_valid(elem_rsp_valid),
        .elem_rsp_data(elem_rsp_data), .elem_rsp_mask(elem_rsp_mask), .done(done),
        .result_we(result_we), .result(result)
    );

    typedef struct packed {
        valuop_t         op;
        logic            uns;
        vsew_t           sew;
        logic [5:0]      vl;
        logic            vm;
        logic [7:0]      mask;
        logic [31:0]     init;
        logic [7:0][31:0] elems;
        logic [31:0]     exp_res;
        logic            exp_we;
        logic            chk_res;
        logic [7:0]      exp_lat;
        logic [3:0]      rsp_lat;
        logic            toggle;
    } vec_t;

    typedef struct packed {
        logic [4:0] idx;
        int         due;
    } pend_t;

    localparam int NV = 12;
    vec_t  tv [NV];
    vec_t  cur;
    pend_t pq [$];
    pend_t hd;
    int    checks, errors;
    int    pcount, acc_count, rsp_sent, max_out, idx_err;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        pcount = 0;
        forever begin
            @(posedge CLK);
            pcount++;
        end
    end

    // Read-port model: accepts on valid&&ready, answers in order after rsp_lat cycles.
    initial begin
        elem_req_ready = 1'b0;
        elem_rsp_valid = 1'b0;
        elem_rsp_data  = '0;
        elem_rsp_mask  = 1'b0;
        forever begin
            @(negedge CLK);
            elem_req_ready = cur.toggle ? pcount[0] : 1'b1;
            if (elem_req_valid && elem_req_ready) begin
                if (elem_idx != 5'(acc_count)) idx_err++;
                pq.push_back('{idx: elem_idx, due: pcount + 1 + int'(cur.rsp_lat)});
                acc_count++;
            end
            if (pq.size() != 0 && pq[0].due <= pcount + 1) begin
                hd = pq.pop_front();
                elem_rsp_valid = 1'b1;
                elem_rsp_data  = cur.elems[hd.idx[2:0]];
                elem_rsp_mask  = cur.mask[hd.idx[2:0]];
                rsp_sent++;
            end else begin
                elem_rsp_valid = 1'b0;
            end
            if (pq.size() > max_out) max_out = pq.size();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input valuop_t op, input logic uns, input vsew_t sew, input int n,
                                input logic vmi, input logic [7:0] msk, input logic [31:0] init,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3,
                                input logic [31:0] exp_res, input logic exp_we,
                                input logic chk_res, input int exp_lat, input int rsp_lat,
                                input logic toggle);
        vec_t v;
        v = '0;
        v.op = op; v.uns = uns; v.sew = sew; v.vl = 6'(n); v.vm = vmi; v.mask = msk;
        v.init = init;
        v.elems[0] = e0; v.elems[1] = e1; v.elems[2] = e2; v.elems[3] = e3;
        v.exp_res = exp_res; v.exp_we = exp_we; v.chk_res = chk_res;
        v.exp_lat = 8'(exp_lat); v.rsp_lat = 4'(rsp_lat); v.toggle = toggle;
        return v;
    endfunction

    // Called at posedge+2: sets up the model and drives start for one cycle.
    task automatic start_op(input vec_t v);
        cur = v; acc_count = 0; rsp_sent = 0; max_out = 0; idx_err = 0;
        start = 1'b1; valuop = v.op; vopunsigned = v.uns; vsew = v.sew; vl = v.vl;
        vm = v.vm; scalar_init = v.init;
        @(posedge CLK); #2;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int  t0;
        int  lat;
        bit  got;
        t0  = pcount + 1;
        start_op(v);
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            if (done) got = 1'b1;
            else begin @(posedge CLK); #2; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout: got no done expected done", name);
        end else begin
            lat = pcount - t0 + 1;
            if (v.exp_lat != 0) chk({name, " latency"}, 32'(lat), 32'(v.exp_lat));
            if (v.chk_res) chk({name, " result"}, result, v.exp_res);
            chk({name, " result_we"}, 32'(result_we), 32'(v.exp_we));
            chk({name, " busy_in_done"}, 32'(busy), 32'h1);
            chk({name, " idx_order"}, 32'(idx_err), 32'h0);
            chk({name, " max_outstanding_ok"}, 32'(max_out <= 4), 32'h1);
            @(posedge CLK); #2;
            chk({name, " done_one_cycle"}, {30'h0, done, busy}, 32'h0);
        end
    endtask

    initial begin
        bit reached;
        bit done_seen;
        checks = 0; errors = 0;
        acc_count = 0; rsp_sent = 0; max_out = 0; idx_err = 0;
        cur = '0; cur.rsp_lat = 4'd1;
        nRST = 1'b0; start = 1'b0; flush = 1'b0; valuop = VALU_ADD; vopunsigned = 1'b0;
        vsew = SEW32; vl = '0; vm = 1'b1; scalar_init = '0;

        tv[0]  = mk(VALU_ADD, 0, SEW32, 4, 1, 8'h00, 32'd10, 1, 2, 3, 4, 32'd20, 1, 1, 7, 1, 0);
        tv[1]  = mk(VALU_MIN, 1, SEW8, 2, 1, 8'h00, 32'h05, 32'hFF, 32'h80, 0, 0, 32'h05, 1, 1, 0, 1, 0);
        tv[2]  = mk(VALU_MIN, 0, SEW8, 2, 1, 8'h00, 32'h05, 32'hFF, 32'h80, 0, 0, 32'h80, 1, 1, 0, 1, 0);
        tv[3]  = mk(VALU_XOR, 0, SEW16, 3, 0, 8'h05, 32'h0, 32'h00F0, 32'hFFFF, 32'h0F00, 0,
                    32'h0FF0, 1, 1, 0, 2, 0);
        tv[4]  = mk(VALU_ADD, 0, SEW32, 8, 1, 8'h00, 32'h0, 1, 1, 1, 1, 32'd8, 1, 1, 0, 5, 1);
        for (int j = 4; j < 8; j++) tv[4].elems[j] = 32'd1;
        tv[5]  = mk(VALU_ADD, 0, SEW32, 0, 1, 8'h00, 32'h1234, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 0);
        tv[6]  = mk(VALU_MIN, 0, SEW8, 1, 0, 8'h00, 32'h7F, 32'h80, 0, 0, 0, 32'h7F, 1, 1, 0, 1, 0);
        tv[7]  = mk(VALU_ADD, 0, SEW8, 2, 1, 8'h00, 32'hF0, 32'h20, 32'h05, 0, 0, 32'h15, 1, 1, 0, 1, 0);
        tv[8]  = mk(VALU_MAX, 1, SEW16, 2, 1, 8'h00, 32'h1, 32'h8000, 32'h7FFF, 0, 0, 32'h8000, 1, 1, 0, 1, 0);
        tv[9]  = mk(VALU_AND, 0, SEW32, 3, 1, 8'h00, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hFF00FF00,
                    32'h0FFFFFFF, 0, 32'h0000F000, 1, 1, 0, 1, 0);
        tv[10] = mk(VALU_OR, 0, SEW16, 2, 1, 8'h00, 32'h0001, 32'hABCD1230, 32'h8000, 0, 0,
                    32'h9231, 1, 1, 0, 1, 1);
        tv[11] = mk(VALU_MAX, 0, SEW32, 3, 1, 8'h00, 32'h80000000, 32'hFFFFFFFF, 32'h5,
                    32'h7FFFFFFE, 0, 32'h7FFFFFFE, 1, 1, 0, 3, 0);

        repeat (3) @(posedge CLK);
        #2;
        chk("reset busy", 32'(busy), 0);
        chk("reset illegal", 32'(illegal), 0);
        chk("reset req_valid", 32'(elem_req_valid), 0);
        chk("reset done_we", {30'h0, done, result_we}, 0);
        chk("reset result", result, 0);
        nRST = 1'b1;
        @(posedge CLK); #2;

        for (int i = 0; i < NV; i++) run_vec(tv[i], $sformatf("vec%0d", i));

        // Unsupported op: one-cycle illegal pulse, never busy.
        start = 1'b1; valuop = VALU_SUB; vl = 6'd2;
        @(posedge CLK); #2;
        start = 1'b0;
        chk("illegal pulse", {30'h0, illegal, busy}, 32'h2);
        @(posedge CLK); #2;
        chk("illegal cleared", {30'h0, illegal, busy}, 32'h0);

        // flush together with start in IDLE: start is dropped.
        start = 1'b1; flush = 1'b1; valuop = VALU_ADD; vl = 6'd2;
        @(posedge CLK); #2;
        start = 1'b0; flush = 1'b0;
        chk("flush_start busy", {30'h0, busy, illegal}, 32'h0);

        // Flush in DRAIN with two responses still in flight.
        start_op(mk(VALU_ADD, 0, SEW32, 4, 1, 8'h00, 32'h0, 1, 2, 3, 4, 0, 0, 0, 0, 5, 0));
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            if (acc_count == 4 && rsp_sent == 2) reached = 1'b1;
            else begin @(posedge CLK); #2; end
        end
        chk("flush reached_drain", 32'(reached), 32'h1);
        flush = 1'b1;
        @(posedge CLK); #2;
        flush = 1'b0;
        chk("flush to_idle", {30'h0, busy, done}, 32'h0);
        done_seen = 1'b0;
        for (int k = 0; k < 40 && (pq.size() != 0 || k < 4); k++) begin
            if (done || busy) done_seen = 1'b1;
            @(posedge CLK); #2;
        end
        chk("flush no_done_or_busy", 32'(done_seen), 32'h0);
        run_vec(tv[0], "post_flush");

        // Asynchronous reset mid-operation returns outputs to zero at once.
        start_op(tv[4]);
        @(posedge CLK); #2;
        nRST = 1'b0;
        #1;
        chk("midreset busy_valid", {30'h0, busy, elem_req_valid}, 32'h0);
        @(posedge CLK); #2;
        nRST = 1'b1;
        for (int k = 0; k < 40 && pq.size() != 0; k++) begin @(posedge CLK); #2; end
        run_vec(tv[3], "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32v_red_sequencer.md
Name: rv32v_red_sequencer

Overview:
- Multi-cycle controller for the VFU_RED unit. It executes vred{sum,and,or,xor,min,minu,max,maxu}.vs.
- Fetches vs2 elements 0..vl-1 in order from the vector register file read port through a pipelined request/response handshake.
- Skips masked-off elements and folds each active element into a scalar accumulator seeded from vs1[0].
- Returns one SEW-wide result destined for vd[0]. Sits between the vector issue stage and the VRF element read port.

Parameters:
- MAX_OUTSTANDING, 4, maximum element requests in flight; power of two, ≥1.
- VLMAX, 32, maximum supported vl; sets the width of vl and elem_idx.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a reduction; sampled only in IDLE
- valuop  in  valuop_t  VALU_ADD/AND/OR/XOR/MIN/MAX; any other value is illegal
- vopunsigned  in  1  1 = unsigned compare for MIN/MAX
- vsew  in  vsew_t  element width SEW8/16/32
- vl  in  $clog2(VLMAX)+1  active element count
- vm  in  1  1 = unmasked; 0 = element mask bit governs activity
- scalar_init  in  32  vs1[0], low SEW bits significant
- flush  in  1  abort the current operation
- busy  out  1  high in any state other than IDLE
- illegal  out  1  one-cycle pulse when start arrives with an unsupported valuop
- elem_req_valid  out  1  element read request
- elem_req_ready  in  1  read port accepts the request
- elem_idx  out  $clog2(VLMAX)  element index being requested
- elem_rsp_valid  in  1  element data is valid
- elem_rsp_data  in  32  element value, low SEW bits significant
- elem_rsp_mask  in  1  v0 mask bit for that element
- done  out  1  one-cycle completion pulse
- result_we  out  1  qualifies result; valid only when done=1
- result  out  32  reduction result; low SEW bits carry the value, upper bits zero

Behaviour:
- Reset: state IDLE; all outputs 0; accumulator, counters and latched op fields 0.
- IDLE:
  - If start and valuop is legal: latch valuop, vopunsigned, vsew, vl and vm; load acc with scalar_init extended per the operand rule; go to FETCH. If vl==0, go to DONE instead.
  - If start and valuop is illegal: pulse illegal next cycle and stay in IDLE.
- FETCH:
  - elem_req_valid=1 while req_cnt<vl and outstanding<MAX_OUTSTANDING; elem_idx=req_cnt.
  - A request is accepted when valid&&ready in the same cycle; req_cnt then increments.
  - When req_cnt reaches vl, go to DRAIN.
- DRAIN: wait until rsp_cnt==vl, then go to DONE.
- Responses: accepted in FETCH and DRAIN. They arrive in request order, at the earliest one cycle after acceptance. Each response increments rsp_cnt.
- Outstanding count = req_cnt - rsp_cnt. An accept and a response in the same cycle leave it unchanged. A response with outstanding==0 is a protocol error: assertion, no state change.
- Element is active if vm==1 or elem_rsp_mask==1. Active elements update acc the cycle after the response; inactive elements leave acc unchanged.
- Operand rule: SEW-truncate the element. Sign-extend to 32 bits unless vopunsigned, in which case zero-extend. The same rule applies to scalar_init.
- ADD wraps modulo 2^SEW. MIN and MAX compare the 32-bit extended values, signed or unsigned per vopunsigned.
- DONE:
  - Lasts exactly one cycle: done=1, result = acc masked to SEW, result_we = (vl!=0). Then return to IDLE.
  - busy remains 1 during DONE, so start is not accepted in the DONE cycle.
- Throughput: one element per cycle when ready is held high and response latency ≤ MAX_OUTSTANDING cycles.
- vl==1 with the element masked off: result = scalar_init, result_we=1.
- flush in any non-IDLE state: go to IDLE next cycle; no done pulse; counters cleared. Responses arriving in IDLE are ignored. The read port is flushed by the same signal.
- flush together with start in IDLE: flush wins and start is ignored.
- nRST asserted mid-operation: immediate return to the reset state.

Decomposition:
- rv32v_types_pkg gains red_state_t {RED_IDLE, RED_FETCH, RED_DRAIN, RED_DONE} and a function red_legal_op(valuop_t).
- Existing valuop_t and vsew_t are reused.
- One sub-module, rv32v_red_alu: combinational (acc, elem, op, sew, unsigned) -> next acc, holding the extension, wrap and compare logic.

Test Plan:
- SEW32 ADD, vl=4, vm=1, init=10, elems 1,2,3,4, ready=1, 1-cycle response latency -> done with result=20, result_we=1; done asserted 7 cycles after start.
- SEW8 MINU vs MIN, vl=2, init=0x05, elems 0xFF,0x80 -> MINU result=0x05; MIN result=0x80 (upper bits 0).
- SEW16 XOR, vl=3, vm=0, masks 1,0,1, elems 0x00F0,0xFFFF,0x0F00, init=0 -> result=0x0FF0.
- Backpressure: elem_req_ready toggling and response latency 5 with MAX_OUTSTANDING=4 -> outstanding never exceeds 4; SEW32 SUM of 8 ones with init 0 -> 8.
- vl=0 -> done one cycle after start with result_we=0. Start with valuop=VALU_SUB -> illegal pulse, busy stays 0.
- flush asserted in DRAIN with 2 responses outstanding -> IDLE next cycle, no done; stray responses ignored; following reduction computes correctly.
